// File: rtl/data_demod_if.sv
// -----------------------------------------------------------------------------
// data_demod_if
//   Bundles the symbol input, the byte read handshake and the status flags of
//   data_demod.
//   master : drives dmod / mod_en / rd_en, observes data_o and the flags
//   slave  : the demodulator side
// -----------------------------------------------------------------------------
interface data_demod_if;
    logic [4:0] dmod;      // modulated symbol, MSB first
    logic       mod_en;    // dmod valid this cycle
    logic       rd_en;     // pop the head byte
    logic [7:0] data_o;    // head byte (show-ahead)
    logic       empty;     // FIFO holds no bytes
    logic       full;      // FIFO holds DEPTH bytes
    logic       overflow;  // sticky byte-dropped flag
    logic       busy;      // FSM not idle

    modport master (
        output dmod, mod_en, rd_en,
        input  data_o, empty, full, overflow, busy
    );

    modport slave (
        input  dmod, mod_en, rd_en,
        output data_o, empty, full, overflow, busy
    );
endinterface

// File: rtl/data_demod.sv
// -----------------------------------------------------------------------------
// data_demod
//   Repacks a 5-bit symbol stream MSB-first into bytes and buffers them in a
//   show-ahead FIFO. A run of IDLE_TO cycles without mod_en closes a burst;
//   the residual bits (fewer than 8) are then either discarded or, with the
//   macro DATA_DEMOD_PAD_EN defined, pushed as one zero-padded byte with the
//   residual bits MSB-aligned.
//
// Parameters
//   DEPTH   : FIFO depth in bytes, power of two, 4..64
//   IDLE_TO : idle cycles in RECV that end a burst, 1..255
//
// Ports
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : data_demod_if.slave (dmod, mod_en, rd_en, data_o, empty, full,
//             overflow, busy)
// -----------------------------------------------------------------------------
module data_demod #(
    parameter int DEPTH   = 16,
    parameter int IDLE_TO = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    data_demod_if.slave  bus
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [7:0]     IDLE_TO_W = 8'(IDLE_TO);

    typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [11:0] acc_q, acc_d;     // only the low cnt_q bits are ever non-zero
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  to_q, to_d;

    // ---------------- symbol accumulation (one symbol, at most one byte)
    logic [16:0] sym_word;
    logic [16:0] sym_mask;
    logic [4:0]  sym_cnt;
    logic [4:0]  sym_shift;
    logic        sym_push;
    logic [7:0]  sym_byte;
    logic [11:0] sym_acc;
    logic [3:0]  sym_cnt_next;
    logic [7:0]  pad_byte;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a signal unassigned and infer a latch.
    always_comb begin
        sym_word     = {acc_q, bus.dmod};
        sym_cnt      = 5'(cnt_q) + 5'd5;
        sym_push     = (sym_cnt >= 5'd8);
        sym_shift    = sym_push ? (sym_cnt - 5'd8) : 5'd0;
        sym_mask     = (17'd1 << sym_shift) - 17'd1;
        sym_byte     = 8'(sym_word >> sym_shift);
        sym_acc      = sym_push ? 12'(sym_word & sym_mask) : 12'(sym_word);
        sym_cnt_next = sym_push ? 4'(sym_shift) : 4'(sym_cnt);
        // residual shifted up so its MSB lands on bit 7
        pad_byte     = 8'(acc_q << (4'd8 - cnt_q));
    end

    // ---------------- FSM next state / accumulator update
    logic       push_req;
    logic [7:0] push_byte;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        push_req  = 1'b0;
        push_byte = 8'h00;

        case (state_q)
            IDLE: begin
                if (bus.mod_en) begin
                    state_d   = RECV;
                    to_d      = 8'd0;
                    acc_d     = sym_acc;
                    cnt_d     = sym_cnt_next;
                    push_req  = sym_push;
                    push_byte = sym_byte;
                end
            end
            RECV: begin
                if (bus.mod_en) begin
                    to_d      = 8'd0;
                    acc_d     = sym_acc;
                    cnt_d     = sym_cnt_next;
                    push_req  = sym_push;
                    push_byte = sym_byte;
                end else if (to_q + 8'd1 == IDLE_TO_W) begin
                    state_d = FLUSH;
                    to_d    = 8'd0;
                end else begin
                    to_d = to_q + 8'd1;
                end
            end
            FLUSH: begin
`ifdef DATA_DEMOD_PAD_EN
                if (cnt_q != 4'd0) begin
                    push_req  = 1'b1;
                    push_byte = pad_byte;
                end
`endif
                to_d = 8'd0;
                // a symbol here starts a fresh accumulation; 5 bits cannot
                // complete a byte, so it never competes with the pad push
                if (bus.mod_en) begin
                    acc_d   = {7'd0, bus.dmod};
                    cnt_d   = 4'd5;
                    state_d = RECV;
                end else begin
                    acc_d   = 12'd0;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FIFO control
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty_w, full_w, overflow_q;
    logic          do_push, do_pop;

    assign empty_w = (count == '0);
    assign full_w  = (count == DEPTH_W);
    assign do_pop  = bus.rd_en & ~empty_w;
    // a pop in the same cycle frees the slot, so a push into a full FIFO is legal
    assign do_push = push_req & (~full_w | do_pop);

    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            acc_q      <= 12'd0;
            cnt_q      <= 4'd0;
            to_q       <= 8'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !do_push) overflow_q <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; stale entries are unreachable
    // because data_o is forced to zero while empty and pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_byte;
    end

    assign bus.data_o   = empty_w ? 8'h00 : mem[rd_ptr];
    assign bus.empty    = empty_w;
    assign bus.full     = full_w;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state_q != IDLE);

endmodule
